// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the instruction/data memory port sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/seq_timeout_counter.sv
// Busy-cycle counter: cleared on every grant, counts while an access is
// outstanding, and flags the last permitted wait cycle (TIMEOUT-1).
module seq_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count busy cycles; a grant restarts the count from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbitrates one single-port memory between instruction fetch and the
// load/store path, holds the memory handshake until ready or timeout, and
// returns a registered one-cycle response per access.
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    seq_state_t state;
    logic       last_grant;
    logic       grant_data;
    logic       grant_fetch;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_expired;

    // Arbitration: data wins when alone or when fetch was granted last.
    always_comb begin
        grant_data  = d_req && (!if_req || (last_grant == GNT_FETCH));
        grant_fetch = if_req && !grant_data;
        cnt_clear   = (state == IDLE) && (if_req || d_req);
        cnt_en      = (state == DATA) || (state == FETCH);
    end

    seq_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    // Sequencer FSM with all memory-side and response outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GNT_FETCH;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            if_err     <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state      <= DATA;
                        last_grant <= GNT_DATA;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                    end else if (grant_fetch) begin
                        state      <= FETCH;
                        last_grant <= GNT_FETCH;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                    end
                end
                DATA, FETCH: begin
                    // A ready in the final wait cycle still counts as success.
                    if (mem_ready || cnt_expired) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (state == DATA) begin
                            d_valid <= 1'b1;
                            d_err   <= !mem_ready;
                            d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= !mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_valid <= 1'b0;
                    if_err   <= 1'b0;
                    d_valid  <= 1'b0;
                    d_err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (if_req && !if_valid) || (d_req && !d_valid);

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Shares one single-port instruction/data memory between two requesters: the datapath instruction fetch (PC) and the load/store path (Mem_WrAddr/Mem_WrData/ReadData).
- Grants one requester at a time and holds the memory handshake until the memory answers or a timeout expires.
- Returns a registered response and drives a stall that freezes the PC register and register-file writes while either access is outstanding.
- Sits between the datapath/controller and the memory model.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 16, max cycles in a busy state waiting for mem_ready; must be >=2; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid.
- if_valid  out  1  one-cycle fetch response pulse.
- if_err  out  1  fetch timed out, qualified by if_valid.
- d_req  in  1  data request, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_valid.
- d_valid  out  1  one-cycle data response pulse.
- d_err  out  1  data access timed out, qualified by d_valid.
- mem_req  out  1  memory request, held until mem_ready or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completion, one cycle.
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
- stall  out  1  pipeline freeze.

Behaviour:
- States: IDLE, DATA, FETCH, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, all outputs 0, timeout counter 0.
  - last_grant=FETCH, so data wins the first contention.
  - Reset mid-access abandons the access: mem_req drops immediately and no response is issued.
- IDLE arbitration:
  - Only d_req: go to DATA.
  - Only if_req: go to FETCH.
  - Both requests: grant the requester not in last_grant (alternating); update last_grant on every grant.
  - On grant, register mem_addr, mem_we (d_we for DATA, 0 for FETCH) and mem_wdata (d_wdata for DATA, 0 for FETCH). All are outputs of flops.
- DATA / FETCH:
  - mem_req=1; mem_addr, mem_we and mem_wdata stay stable; counter increments each cycle.
  - On mem_ready=1: capture mem_rdata into the granted port's rdata register (0 for stores), err=0, go to RESP.
  - If mem_ready does not arrive and the counter reaches TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - mem_req deasserts on entry to RESP.
  - mem_ready while in IDLE or RESP is ignored.
- RESP:
  - Exactly one of if_valid/d_valid is 1 for one cycle, with its err bit.
  - Next state is always IDLE. The requester drops req after sampling valid; RESP stops a still-high req from being re-granted.
- Latency:
  - Request in cycle 0, mem_req in cycle 1, mem_ready earliest in cycle 1, valid earliest in cycle 2. Minimum 3 cycles per access.
  - Back-to-back accesses: next grant in the first IDLE cycle.
- rdata registers hold their value until the next response for the same port.
- stall = (if_req & ~if_valid) | (d_req & ~d_valid). Combinational.
- Requester address/data changes while req is high and the requester is not yet granted: the value sampled at the grant edge is used.
- Counter resets to 0 on every grant.

Decomposition:
- Shared package mem_seq_pkg holds:
  - State encoding enum: IDLE=2'd0, DATA=2'd1, FETCH=2'd2, RESP=2'd3.
  - Grant-id constants GNT_FETCH=1'b0 and GNT_DATA=1'b1.
- One sub-module: seq_timeout_counter (clear, enable, expire at TIMEOUT-1).
- Arbitration and FSM stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000010, mem_ready one cycle after mem_req with rdata=0x00500093 -> mem_addr=0x10, mem_we=0, if_valid pulse with if_rdata=0x00500093, if_err=0, stall=1 until the valid cycle.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 cycles -> mem_req high 3 cycles, mem_we=1, mem_wdata=0xDEADBEEF, d_valid with d_rdata=0.
- Contention after reset: if_req and d_req both rise in the same cycle -> DATA granted first, then FETCH with no idle gap beyond RESP/IDLE. Repeated simultaneous requests alternate D,F,D,F.
- Timeout, TIMEOUT=16: load with mem_ready never asserted -> mem_req high exactly 16 cycles, then d_valid=1 with d_err=1 and d_rdata=0. A following fetch completes normally.
- Reset mid-access: assert reset low during FETCH between clock edges -> mem_req=0 immediately, no if_valid after release, first grant after release goes to DATA if both are pending.
- Stray mem_ready pulse in IDLE -> no valid pulse, state unchanged.
